// File: rtl/vga_capture.sv
// vga_capture: measures incoming VGA timing, tracks lock, and on request
// copies a fixed 256x256 window of one frame into an external frame RAM.
//
// Ports
//   clk        : pixel clock (single clock domain)
//   rst        : synchronous, active-high reset
//   vga_hs     : incoming horizontal sync (asserted level = SYNC_POL)
//   vga_vs     : incoming vertical sync (asserted level = SYNC_POL)
//   vga_rgb    : incoming 8-bit pixel
//   capture_en : one-cycle request to capture the next locked frame window
//   wr_en      : frame-RAM write strobe
//   wr_addr    : frame-RAM address {row[7:0], col[7:0]}
//   wr_data    : pixel written
//   busy       : capture in progress (ARM, CAPT or FIN)
//   done       : one-cycle pulse when the window has been fully written
//   err        : one-cycle pulse when a capture is aborted
//   locked     : timing stable over a whole frame
//   h_total    : measured clocks per line
//   v_total    : measured lines per frame
module vga_capture #(
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter int   WIN_X    = 272,
    parameter int   WIN_Y    = 172,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [7:0]  vga_rgb,
    input  logic        capture_en,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        locked,
    output logic [10:0] h_total,
    output logic [9:0]  v_total
);

    typedef enum logic [1:0] {IDLE, ARM, CAPT, FIN} state_t;

    // Window bounds expressed directly in raw counter space (sync + porch + offset).
    localparam logic [11:0] H_LO  = 12'(H_SYNC + H_BP + WIN_X);
    localparam logic [11:0] H_HI  = 12'(H_SYNC + H_BP + WIN_X + 256);
    localparam logic [10:0] V_LO  = 11'(V_SYNC + V_BP + WIN_Y);
    localparam logic [10:0] V_HI  = 11'(V_SYNC + V_BP + WIN_Y + 256);
    localparam logic [7:0]  H_LO8 = 8'(H_SYNC + H_BP + WIN_X);
    localparam logic [7:0]  V_LO8 = 8'(V_SYNC + V_BP + WIN_Y);

    function automatic logic [10:0] inc_sat11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] inc_sat10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [7:0]  rgb_q;
    logic [10:0] hcnt_q, h_total_q;
    logic [9:0]  vcnt_q, v_total_q;
    logic        frame_ok_q, locked_q;
    logic [1:0]  seen_q;
    state_t      state_q;
    logic        wr_en_q, busy_q, done_q, err_q;
    logic [15:0] wr_addr_q;
    logic [7:0]  wr_data_q;

    logic        hs_start, vs_start, h_ok, v_ok, in_win, locked_d;
    logic [10:0] ht_new, px;
    logic [9:0]  vt_new, py;
    logic [7:0]  row8, col8;

    assign hs_start = (hs_q == SYNC_POL) && (hs_prev_q != SYNC_POL);
    assign vs_start = (vs_q == SYNC_POL) && (vs_prev_q != SYNC_POL);

    always_comb begin
        ht_new = inc_sat11(hcnt_q);
        vt_new = inc_sat10(vcnt_q);
        h_ok   = (ht_new == h_total_q);
        v_ok   = (vt_new == v_total_q);
        // Position of the pixel now in rgb_q: the counters only reach this
        // value at the coming edge, so use their next-state values.
        px     = hs_start ? 11'd0 : ht_new;
        py     = vs_start ? 10'd0 : (hs_start ? vt_new : vcnt_q);
        in_win = ({1'b0, px} >= H_LO) && ({1'b0, px} < H_HI) &&
                 ({1'b0, py} >= V_LO) && ({1'b0, py} < V_HI);
        row8   = py[7:0] - V_LO8;
        col8   = px[7:0] - H_LO8;
        // Lock is decided at frame end: two full frames seen, every line of the
        // ending frame (including the one closing now) matched its predecessor.
        locked_d = locked_q;
        if (vs_start) begin
            locked_d = (seen_q == 2'd2) && frame_ok_q && v_ok && (!hs_start || h_ok);
        end else if (hs_start && !h_ok) begin
            locked_d = 1'b0;
        end
    end

    // stage 0: input registers, timing measurement and lock tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            hs_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            rgb_q      <= 8'd0;
            hcnt_q     <= 11'd0;
            vcnt_q     <= 10'd0;
            h_total_q  <= 11'd0;
            v_total_q  <= 10'd0;
            frame_ok_q <= 1'b0;
            seen_q     <= 2'd0;
            locked_q   <= 1'b0;
        end else begin
            hs_q      <= vga_hs;
            vs_q      <= vga_vs;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
            rgb_q     <= vga_rgb;
            if (hs_start) begin
                hcnt_q    <= 11'd0;
                h_total_q <= ht_new;
            end else begin
                hcnt_q <= ht_new;
            end
            if (vs_start) begin
                vcnt_q    <= 10'd0;
                v_total_q <= vt_new;
            end else if (hs_start) begin
                vcnt_q <= vt_new;
            end
            if (vs_start) begin
                frame_ok_q <= 1'b1;
                if (seen_q != 2'd2) seen_q <= seen_q + 2'd1;
            end else if (hs_start && !h_ok) begin
                frame_ok_q <= 1'b0;
            end
            locked_q <= locked_d;
        end
    end

    // stage 1: capture FSM with registered write port and status
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 16'd0;
            wr_data_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (capture_en) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                    end
                end
                ARM: begin
                    if (vs_start && locked_q) state_q <= CAPT;
                end
                CAPT: begin
                    // Abort on the same edge that drops lock, before any further write.
                    if (vs_start || !locked_d) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (in_win) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= {row8, col8};
                        wr_data_q <= rgb_q;
                        if ({row8, col8} == 16'hFFFF) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign locked  = locked_q;
    assign h_total = h_total_q;
    assign v_total = v_total_q;

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 The block SHALL have parameter H_SYNC, default 128, meaning hsync width in clocks.
REQ-002 The block SHALL have parameter H_BP, default 88, meaning horizontal back porch in clocks.
REQ-003 The block SHALL have parameter V_SYNC, default 4, meaning vsync width in lines.
REQ-004 The block SHALL have parameter V_BP, default 23, meaning vertical back porch in lines.
REQ-005 The block SHALL have parameters WIN_X, default 272, and WIN_Y, default 172, meaning the top-left active-area coordinate of a fixed 256x256 capture window.
REQ-006 The block SHALL have parameter SYNC_POL, default 1, meaning sync asserted level.
REQ-007 The block SHALL have port clk, input, 1 bit: the 40 MHz pixel clock, the only clock.
REQ-008 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have port vga_hs, input, 1 bit: incoming horizontal sync.
REQ-010 The block SHALL have port vga_vs, input, 1 bit: incoming vertical sync.
REQ-011 The block SHALL have port vga_rgb, input, 8 bits: incoming pixel data.
REQ-012 The block SHALL have port capture_en, input, 1 bit: single-cycle request to capture one frame window.
REQ-013 The block SHALL have port wr_en, output, 1 bit: frame-RAM write strobe.
REQ-014 The block SHALL have port wr_addr, output, 16 bits: frame-RAM address {row[7:0], col[7:0]}.
REQ-015 The block SHALL have port wr_data, output, 8 bits: pixel written.
REQ-016 The block SHALL have ports busy, done, err and locked, all outputs of 1 bit each.
REQ-017 The block SHALL have port h_total, output, 11 bits: measured clocks per line.
REQ-018 The block SHALL have port v_total, output, 10 bits: measured lines per frame.

Function
REQ-019 All three VGA inputs SHALL be registered once; all logic SHALL operate on the registered copies.
REQ-020 A sync start SHALL be the registered sync changing from not-asserted to SYNC_POL.
REQ-021 On hs start, hcnt SHALL load 0, h_total SHALL load the old hcnt+1, and otherwise hcnt SHALL increment, saturating at 2047.
REQ-022 On vs start, vcnt SHALL load 0 and v_total SHALL load the old vcnt+1; on hs start alone, vcnt SHALL increment, saturating at 1023.
REQ-023 Coincident hs and vs starts SHALL apply both REQ-021 and REQ-022, with vs taking priority for vcnt.
REQ-024 Pixel coordinates SHALL be x = hcnt-(H_SYNC+H_BP) and y = vcnt-(V_SYNC+V_BP); a pixel lies in the window iff WIN_X<=x<WIN_X+256 and WIN_Y<=y<WIN_Y+256.
REQ-025 Lock: locked SHALL set when two consecutive frames give equal v_total and every line within the second frame gives h_total equal to the preceding line.
REQ-026 Any h_total or v_total mismatch against the previous value SHALL clear locked on the cycle after the offending sync start.
REQ-027 The FSM SHALL have states IDLE, ARM, CAPT and FIN.
REQ-028 IDLE SHALL go to ARM when capture_en=1; capture_en SHALL be ignored in all other states.
REQ-029 ARM SHALL go to CAPT on a vs start while locked=1, and SHALL stay in ARM otherwise.
REQ-030 In CAPT, each in-window pixel SHALL produce exactly one cycle of wr_en=1 with wr_addr={y-WIN_Y, x-WIN_X}[7:0 each] and wr_data equal to that pixel.
REQ-031 wr_en, wr_addr and wr_data SHALL be registered, appearing 2 clocks after the pixel is present on vga_rgb.
REQ-032 CAPT SHALL go to FIN after the write at wr_addr=16'hFFFF.
REQ-033 FIN SHALL last one cycle with done=1, then go to IDLE.
REQ-034 Abort: CAPT SHALL go to IDLE with err=1 for one cycle and no further writes if locked falls or a vs start occurs before wr_addr=16'hFFFF.
REQ-035 busy SHALL be 1 in ARM, CAPT and FIN, and 0 in IDLE.
REQ-036 wr_en SHALL be 0 outside CAPT.

Reset
REQ-037 rst=1 at a clk edge SHALL force IDLE and clear all counters, lock history and input registers.
REQ-038 rst=1 at a clk edge SHALL set wr_en, wr_addr, wr_data, busy, done, err, locked, h_total and v_total to 0 on the following cycle.
REQ-039 rst during CAPT SHALL abort without asserting err or done.
REQ-040 After reset, locked SHALL require two full frames per REQ-025 before asserting.

Verification
REQ-041 The bench SHALL apply standard 800x600@60 (1056x628, positive sync) stimulus and check h_total=1056, v_total=628, and locked=1 by the end of frame 2.
REQ-042 The bench SHALL pulse capture_en in IDLE with pixel value (x+y)&8'hFF and check that exactly 65536 writes occur with wr_addr 0..FFFF in order, that wr_data at addr {r,c} is (c+272+r+172)&8'hFF, and that done is pulsed once.
REQ-043 The bench SHALL shorten one line to 1055 clocks mid-capture and check locked=0 the cycle after that hs start, err=1 for one cycle, then no wr_en and busy=0.
REQ-044 The bench SHALL pulse capture_en with locked=0 and check that the FSM stays in ARM with busy=1 and no writes until lock is reached, then captures the next frame.
REQ-045 The bench SHALL assert rst for 1 cycle at wr_addr=16'h1234 and check that all outputs are 0 on the next cycle, with no done and no err.
REQ-046 The bench SHALL pulse capture_en during CAPT and check that it has no effect, with exactly one done.
